// File: rtl/tpu_pkg.sv
// Shared TPU types: feed sequencer states and the common byte type.
// Imported by the systolic feed controller.
package tpu_pkg;

  typedef logic [7:0] byte_type;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } feed_state_type;

endpackage

// File: rtl/systolic_valid_skew.sv
// Enable-gated diagonal valid skew: lane 0 is the live input bit,
// lane i is lane i-1 delayed by one enabled cycle.
module systolic_valid_skew #(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] lane_valid
);

  generate
    if (WIDTH == 1) begin : g_one
      assign lane_valid = din;
    end else begin : g_shift
      logic [WIDTH-2:0] stages;

      always_ff @(posedge clk) begin
        if (rst) begin
          stages <= '0;
        end else if (en) begin
          stages <= lane_valid[WIDTH-2:0];
        end
      end

      assign lane_valid = {stages, din};
    end
  endgenerate

endmodule

// File: rtl/systolic_feed_controller.sv
// Matrix-multiply feed sequencer: buffer reads, setup enable, skew drain.
// Optional TPU_FEED_PERF_EN adds a saturating stall_count output.
module systolic_feed_controller
  import tpu_pkg::*;
#(
  parameter int MATRIX_WIDTH     = 14,
  parameter int ADDR_WIDTH       = 24,
  parameter int LENGTH_WIDTH     = 32,
  parameter int BUF_READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic [ADDR_WIDTH-1:0]   instr_addr,
  input  logic [LENGTH_WIDTH-1:0] instr_length,
  input  logic                    stall,
  output logic                    buf_rd_en,
  output logic [ADDR_WIDTH-1:0]   buf_rd_addr,
  output logic                    feed_valid,
  output logic                    setup_enable,
  output logic [MATRIX_WIDTH-1:0] lane_valid,
  output logic                    busy,
  output logic                    done
`ifdef TPU_FEED_PERF_EN
  ,
  output logic [31:0]             stall_count
`endif
);

  localparam int R  = BUF_READ_LATENCY;
  localparam int DW = $clog2(MATRIX_WIDTH + 1);

  feed_state_type          state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LENGTH_WIDTH-1:0] remain;
  logic [R-1:0]            rd_pipe;
  logic [R-1:0]            pending;
  logic [DW-1:0]           drain_cnt;
  logic                    rd_fire;
  logic                    feed_done;

  assign rd_fire   = (state == FEED) && !stall
                   && (remain != '0);
  // reads still in flight after this cycle's returning one
  assign pending   = rd_pipe << 1;
  assign feed_done = (state == FEED) && (remain == '0)
                   && (pending == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      remain    <= '0;
      rd_pipe   <= '0;
      drain_cnt <= '0;
    end else begin
      rd_pipe <= pending | R'(rd_fire);
      unique case (state)
        IDLE: begin
          if (instr_valid) begin
            addr_q <= instr_addr;
            remain <= instr_length;
            state  <= (instr_length == '0) ? DONE : FEED;
          end
        end
        FEED: begin
          if (rd_fire) begin
            addr_q <= addr_q + 1'b1;
            remain <= remain - 1'b1;
          end
          if (feed_done) begin
            drain_cnt <= DW'(MATRIX_WIDTH - 1);
            state     <= (MATRIX_WIDTH == 1) ? DONE : DRAIN;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt - 1'b1;
          if (drain_cnt == DW'(1)) begin
            state <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign instr_ready  = (state == IDLE);
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign buf_rd_en    = rd_fire;
  assign buf_rd_addr  = addr_q;
  assign feed_valid   = rd_pipe[R-1];
  assign setup_enable = ((state == FEED) && feed_valid)
                      || (state == DRAIN);

  systolic_valid_skew #(
    .WIDTH(MATRIX_WIDTH)
  ) u_skew (
    .clk       (clk),
    .rst       (rst),
    .en        (setup_enable),
    .din       (feed_valid),
    .lane_valid(lane_valid)
  );

`ifdef TPU_FEED_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if ((state == IDLE) && instr_valid) begin
      stall_q <= '0;
    end else if ((state == FEED) && stall
                 && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_systolic_feed_controller.sv
// Bench for systolic_feed_controller (W=4, R=1): directed table,
// hand-written handshake/reset sequences, randomized model checks.
module tb_systolic_feed_controller;

  localparam int W  = 4;
  localparam int R  = 1;
  localparam int AW = 24;
  localparam int LW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          instr_valid;
  logic          instr_ready;
  logic [AW-1:0] instr_addr;
  logic [LW-1:0] instr_length;
  logic          stall;
  logic          buf_rd_en;
  logic [AW-1:0] buf_rd_addr;
  logic          feed_valid;
  logic          setup_enable;
  logic [W-1:0]  lane_valid;
  logic          busy;
  logic          done;
`ifdef TPU_FEED_PERF_EN
  logic [31:0]   stall_count;
`endif

  always #5 clk = ~clk;

  systolic_feed_controller #(
    .MATRIX_WIDTH    (W),
    .ADDR_WIDTH      (AW),
    .LENGTH_WIDTH    (LW),
    .BUF_READ_LATENCY(R)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_addr  (instr_addr),
    .instr_length(instr_length),
    .stall       (stall),
    .buf_rd_en   (buf_rd_en),
    .buf_rd_addr (buf_rd_addr),
    .feed_valid  (feed_valid),
    .setup_enable(setup_enable),
    .lane_valid  (lane_valid),
    .busy        (busy),
    .done        (done)
`ifdef TPU_FEED_PERF_EN
    ,
    .stall_count (stall_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  bit            m_rd   [64];
  logic [AW-1:0] m_addr [64];
  bit            m_fv   [64];
  bit            m_se   [64];
  logic [W-1:0]  m_lane [64];
  int            m_done;
  int            m_stalls;

  typedef struct {
    logic [AW-1:0] addr;
    int            len;
    logic [63:0]   smask;
    int            exp_done;
    int            exp_stalls;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Timeline built from the row/stall rules: reads go out on
  // non-stalled cycles, return R later, then W-1 zero rows drain.
  task automatic build_model(input logic [AW-1:0] a,
                             input int len,
                             input logic [63:0] smask);
    int issued = 0;
    int last   = 0;
    bit hist[$];
    for (int c = 0; c < 64; c++) begin
      m_rd[c] = 0; m_addr[c] = '0; m_fv[c] = 0;
      m_se[c] = 0; m_lane[c] = '0;
    end
    m_stalls = 0;
    if (len == 0) begin
      m_done = 1;
      return;
    end
    for (int c = 1; c < 64 && issued < len; c++) begin
      if (!smask[c]) begin
        m_rd[c]   = 1;
        m_addr[c] = a + AW'(issued);
        issued++;
        last = c;
      end
    end
    m_done = last + R + W;
    for (int c = 1; c <= last + R; c++)
      if (smask[c]) m_stalls++;
    for (int c = 1; c <= m_done; c++) begin
      m_fv[c] = (c - R >= 1) ? m_rd[c-R] : 1'b0;
      m_se[c] = (c <= last + R) ? m_fv[c] : (c < m_done);
      m_lane[c][0] = m_fv[c];
      for (int i = 1; i < W; i++)
        m_lane[c][i] = (hist.size() >= i)
                     ? hist[hist.size()-i] : 1'b0;
      if (m_se[c]) hist.push_back(m_fv[c]);
    end
  endtask

  task automatic run_instr(input logic [AW-1:0] a,
                           input int len,
                           input logic [63:0] smask,
                           output int obs_done);
    build_model(a, len, smask);
    obs_done = -1;
    next_cycle();
    instr_valid  = 1'b1;
    instr_addr   = a;
    instr_length = LW'(len);
    stall        = smask[0];
    sample();
    chk("hs_ready", instr_ready, 1);
    for (int c = 1; c <= m_done + 1; c++) begin
      next_cycle();
      instr_valid = 1'b0;
      stall       = smask[c];
      sample();
      if (done && obs_done < 0) obs_done = c;
      chk("rd_en", buf_rd_en, m_rd[c]);
      if (m_rd[c]) chk("rd_addr", buf_rd_addr, m_addr[c]);
      chk("feed_valid", feed_valid, m_fv[c]);
      chk("setup_enable", setup_enable, m_se[c]);
      chk("lane_valid", lane_valid, m_lane[c]);
      chk("done", done, c == m_done);
      chk("busy", busy, c <= m_done);
      chk("instr_ready", instr_ready, c > m_done);
    end
`ifdef TPU_FEED_PERF_EN
    chk("stall_count", stall_count, m_stalls);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int obs;
    logic [63:0] m;
    logic [AW-1:0] a;
    int len;

    vt[0] = '{24'h000010, 3, 64'h0,   8, 0};
    vt[1] = '{24'h000010, 3, 64'h38C, 10, 2};
    vt[2] = '{24'h000010, 3, 64'hE0,  8, 0};
    vt[3] = '{24'h000000, 0, 64'h0,   1, 0};
    vt[4] = '{24'hFFFFFF, 2, 64'h0,   7, 0};

    rst = 1'b1; instr_valid = 1'b0; stall = 1'b0;
    instr_addr = '0; instr_length = '0;
    repeat (2) @(posedge clk);
    sample();
    chk("rst_ready", instr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", buf_rd_en, 0);
    chk("rst_rd_addr", buf_rd_addr, 0);
    chk("rst_feed_valid", feed_valid, 0);
    chk("rst_setup_enable", setup_enable, 0);
    chk("rst_lane_valid", lane_valid, 0);
    next_cycle();
    rst = 1'b0;
    sample();

    for (int k = 0; k < 5; k++) begin
      run_instr(vt[k].addr, vt[k].len, vt[k].smask, obs);
      chk("done_cycle", obs, vt[k].exp_done);
`ifdef TPU_FEED_PERF_EN
      chk("tbl_stall_count", stall_count, vt[k].exp_stalls);
`endif
    end

    for (int c = 0; c <= 16; c++) begin
      next_cycle();
      stall = 1'b0;
      if (c == 0) begin
        instr_valid = 1'b1; instr_addr = 24'h10; instr_length = 3;
      end else if (c >= 3 && c <= 9) begin
        instr_valid = 1'b1; instr_addr = 24'h40; instr_length = 1;
      end else begin
        instr_valid = 1'b0;
      end
      sample();
      if (c >= 3 && c <= 8) chk("held_ready_low", instr_ready, 0);
      if (c == 9) chk("held_ready", instr_ready, 1);
      if (c == 10) begin
        chk("held_rd_en", buf_rd_en, 1);
        chk("held_rd_addr", buf_rd_addr, 24'h40);
      end
      chk("held_done", done, (c == 8) || (c == 15));
    end

    for (int c = 0; c <= 12; c++) begin
      next_cycle();
      rst = (c == 3);
      if (c == 0) begin
        instr_valid = 1'b1; instr_addr = 24'h10; instr_length = 3;
      end else if (c == 4) begin
        instr_valid = 1'b1; instr_addr = 24'h20; instr_length = 1;
      end else begin
        instr_valid = 1'b0;
      end
      sample();
      if (c == 4) begin
        chk("mrst_ready", instr_ready, 1);
        chk("mrst_busy", busy, 0);
        chk("mrst_rd_en", buf_rd_en, 0);
        chk("mrst_rd_addr", buf_rd_addr, 0);
        chk("mrst_feed_valid", feed_valid, 0);
        chk("mrst_setup_enable", setup_enable, 0);
        chk("mrst_lane_valid", lane_valid, 0);
      end
      if (c == 5) begin
        chk("mrst_new_rd_en", buf_rd_en, 1);
        chk("mrst_new_rd_addr", buf_rd_addr, 24'h20);
      end
      if (c >= 4) chk("mrst_done", done, c == 10);
    end

    repeat (30) begin
      len = $urandom_range(0, 8);
      a   = AW'($urandom);
      if ($urandom_range(0, 3) == 0) a = 24'hFFFFFF - AW'($urandom_range(0, 3));
      m = '0;
      for (int c = 1; c <= 20; c++)
        if ($urandom_range(0, 3) == 0) m[c] = 1'b1;
      repeat ($urandom_range(0, 2)) begin
        next_cycle();
        instr_valid = 1'b0;
        stall = 1'($urandom);
        sample();
      end
      run_instr(a, len, m, obs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
